// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-NUM_CH valid/ready stream demultiplexer.
//   Each output channel has a one-entry holding register. A stalled channel
//   does not block words routed to the other channels.
//   Optional macro STREAM_DEMUX_BCAST_EN adds in_bcast. When in_bcast=1, the
//   incoming word is loaded into every channel at once.
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    producer handshake; in_ready is combinational
//   in_data, in_sel      payload and destination channel index
//   in_bcast             (STREAM_DEMUX_BCAST_EN only) send the word to all channels
//   out_valid/out_ready  per-channel consumer handshake, bit i = channel i
//   out_data             channel i occupies bits [i*DATA_W +: DATA_W]
//   err_sel              one-cycle pulse after a word with in_sel >= NUM_CH is dropped
//   drop_cnt             saturating count of dropped words
module stream_demux #(
   parameter int DATA_W = 8,
   parameter int NUM_CH = 4,
   parameter int SEL_W  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
`ifdef STREAM_DEMUX_BCAST_EN
   input  logic                     in_bcast,
`endif
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   input  logic [SEL_W-1:0]         in_sel,
   output logic [NUM_CH-1:0]        out_valid,
   input  logic [NUM_CH-1:0]        out_ready,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic                     err_sel,
   output logic [7:0]               drop_cnt
);

   logic              bcast;
   logic [NUM_CH-1:0] free;
   logic [NUM_CH-1:0] dec;
   logic [NUM_CH-1:0] load;
   logic              sel_hit;
   logic              accept;
   logic              drop;

`ifdef STREAM_DEMUX_BCAST_EN
   assign bcast = in_bcast;
`else
   assign bcast = 1'b0;
`endif

   // A slot can take a word if it is empty or is being drained this cycle.
   assign free = ~out_valid | out_ready;

   // The one-hot decode covers only the real channels. If in_sel >= NUM_CH,
   // no bit is set, so sel_hit identifies an invalid select without ever
   // indexing past the channel vector.
   always_comb begin
      dec = '0;
      for (int i = 0; i < NUM_CH; i++)
         dec[i] = (in_sel == SEL_W'(i));
   end

   assign sel_hit  = |dec;
   assign in_ready = bcast ? &free : (sel_hit ? |(dec & free) : 1'b1);
   assign accept   = in_valid & in_ready;
   assign load     = accept ? (bcast ? {NUM_CH{1'b1}} : dec) : '0;
   assign drop     = accept & ~bcast & ~sel_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= '0;
         out_data  <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            // A refill wins over a drain, so back-to-back words keep valid high.
            out_valid[i] <= load[i] | (out_valid[i] & ~out_ready[i]);
            if (load[i])
               out_data[i*DATA_W +: DATA_W] <= in_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_sel  <= 1'b0;
         drop_cnt <= 8'd0;
      end else begin
         err_sel <= drop;
         if (drop && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed self-checking bench for stream_demux.
//   The DUT is built with NUM_CH=3 and SEL_W=2, so select value 3 is an
//   invalid channel. If STREAM_DEMUX_BCAST_EN is defined, the broadcast
//   feature is also exercised.
module tb_stream_demux;

   localparam int DW = 8;
   localparam int NC = 3;
   localparam int SW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   in_data;
   logic [SW-1:0]   in_sel;
   logic [NC-1:0]   out_valid;
   logic [NC-1:0]   out_ready;
   logic [NC*DW-1:0] out_data;
   logic            err_sel;
   logic [7:0]      drop_cnt;
`ifdef STREAM_DEMUX_BCAST_EN
   logic            in_bcast = 1'b0;
`endif

   int vectors = 0;
   int miscompares = 0;

   stream_demux #(.DATA_W(DW), .NUM_CH(NC), .SEL_W(SW)) dut (
      .clk(clk),
      .rst(rst),
`ifdef STREAM_DEMUX_BCAST_EN
      .in_bcast(in_bcast),
`endif
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_sel(in_sel),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .err_sel(err_sel),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] ch(input int i);
      return out_data[i*DW +: DW];
   endfunction

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0;
      step(); step();
      rst = 1'b0;
      #1;
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_data", 32'(out_data), 32'h0);
      chk("rst_err", 32'(err_sel), 32'h0);
      chk("rst_cnt", 32'(drop_cnt), 32'h0);

      // Route a word to channel 2, then try to send a second word while ch2 is stalled.
      in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5;
      #1 chk("rdy_sel2_empty", 32'(in_ready), 32'h1);
      step();
      in_data = 8'h77;
      #1;
      chk("route_valid", 32'(out_valid), 32'b100);
      chk("route_data2", 32'(ch(2)), 32'hA5);
      chk("rdy_sel2_full", 32'(in_ready), 32'h0);
      step();
      in_sel = 2'd1; in_data = 8'h3C;
      #1 chk("rdy_sel1", 32'(in_ready), 32'h1);
      step();
      in_valid = 1'b0;
      #1;
      chk("route2_valid", 32'(out_valid), 32'b110);
      chk("route2_data1", 32'(ch(1)), 32'h3C);
      chk("hold_data2", 32'(ch(2)), 32'hA5);

      // Stream three words into channel 0 while its consumer is always ready.
      out_ready = 3'b001;
      in_valid = 1'b1; in_sel = 2'd0;
      for (int k = 1; k <= 3; k++) begin
         in_data = 8'(k);
         #1 chk("stream_rdy", 32'(in_ready), 32'h1);
         step();
         chk("stream_valid0", 32'(out_valid[0]), 32'h1);
         chk("stream_data0", 32'(ch(0)), 32'(k));
      end
      in_valid = 1'b0;
      step();
      chk("drain_valid", 32'(out_valid), 32'b110);
      chk("drain_keep_data", 32'(ch(0)), 32'h03);

      // Send a word with an invalid select (3 >= NUM_CH).
      out_ready = 3'b000;
      in_valid = 1'b1; in_sel = 2'd3; in_data = 8'hFF;
      #1 chk("rdy_bad_sel", 32'(in_ready), 32'h1);
      step();
      in_valid = 1'b0;
      #1;
      chk("err_pulse", 32'(err_sel), 32'h1);
      chk("drop_cnt1", 32'(drop_cnt), 32'h1);
      chk("bad_valid_same", 32'(out_valid), 32'b110);
      step();
      chk("err_clear", 32'(err_sel), 32'h0);
      in_valid = 1'b1;
      for (int k = 0; k < 300; k++) step();
      chk("drop_sat", 32'(drop_cnt), 32'hFF);
      chk("err_held", 32'(err_sel), 32'h1);
      in_valid = 1'b0;
      step();
      chk("drop_sat_hold", 32'(drop_cnt), 32'hFF);
      chk("err_clear2", 32'(err_sel), 32'h0);

      // Fill every slot, then assert reset in the middle of a cycle.
      in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h11;
      step();
      in_valid = 1'b0;
      chk("full_valid", 32'(out_valid), 32'b111);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'h0);
      chk("async_rst_cnt", 32'(drop_cnt), 32'h0);
      chk("async_rst_data", 32'(out_data), 32'h0);
      step();
      rst = 1'b0;
      in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h22;
      #1 chk("post_rst_rdy", 32'(in_ready), 32'h1);
      step();
      in_valid = 1'b0;
      chk("post_rst_valid", 32'(out_valid), 32'b001);
      chk("post_rst_data0", 32'(ch(0)), 32'h22);

`ifdef STREAM_DEMUX_BCAST_EN
      // Broadcast is blocked while channels 0 and 2 are stalled. It proceeds once they drain.
      in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h33;
      step();
      chk("bc_pre_valid", 32'(out_valid), 32'b101);
      in_bcast = 1'b1; in_sel = 2'd3; in_data = 8'h5A;
      #1 chk("bc_blocked", 32'(in_ready), 32'h0);
      out_ready = 3'b101;
      #1 chk("bc_rdy", 32'(in_ready), 32'h1);
      step();
      in_valid = 1'b0; in_bcast = 1'b0; out_ready = 3'b000;
      #1;
      chk("bc_valid", 32'(out_valid), 32'b111);
      chk("bc_data", 32'(out_data), {8'h0, 24'h5A5A5A});
      chk("bc_no_err", 32'(err_sel), 32'h0);
      chk("bc_no_drop", 32'(drop_cnt), 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
